// File: rtl/sexpr_eval_if.sv
// rtl/sexpr_eval_if.sv - token stream in / BUS result out handshake bundle for sexpr_eval
interface sexpr_eval_if #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_tok;
    logic             out_valid;
    logic             out_ready;
    logic [DEPTH-1:0] y;
    logic [CW-1:0]    y_count;
    logic             err;

    modport master (
        output in_valid, in_tok, out_ready,
        input  in_ready, out_valid, y, y_count, err
    );

    modport slave (
        input  in_valid, in_tok, out_ready,
        output in_ready, out_valid, y, y_count, err
    );
endinterface

// File: rtl/sexpr_eval.sv
// rtl/sexpr_eval.sv - postfix logic-expression evaluator on a bit stack, emits BUS word
module sexpr_eval #(
    parameter int N_IN  = 32,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] in_vec,
    sexpr_eval_if.slave     bus
);
    typedef enum logic [1:0] {S_ACC, S_EMIT, S_DRAIN} state_t;

    localparam logic [2:0] OP_CONST = 3'd0;
    localparam logic [2:0] OP_VAR   = 3'd1;
    localparam logic [2:0] OP_NOT   = 3'd2;
    localparam logic [2:0] OP_AND   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_XOR   = 3'd5;
    localparam logic [2:0] OP_MUX   = 3'd6;
    localparam logic [2:0] OP_END   = 3'd7;

    localparam logic [DEPTH-1:0] ONE  = DEPTH'(1);
    localparam logic [N_IN-1:0]  VONE = N_IN'(1);

    state_t           state, state_nx;
    logic [DEPTH-1:0] stk;
    logic [CW-1:0]    sp;
    logic [DEPTH-1:0] y_r;
    logic [CW-1:0]    y_count_r;
    logic             err_r;

    logic [2:0]       op;
    logic [4:0]       opd;
    logic             accept;
    logic [CW-1:0]    sp_m1, sp_m2, sp_m3;
    logic             t1, t2, t3;
    logic             vec_bit;
    logic             res;
    logic [CW-1:0]    wpos;
    logic [CW-1:0]    sp_new;
    logic             tok_err;
    logic [DEPTH-1:0] stk_upd;
    logic [DEPTH-1:0] low_mask;

    assign op     = bus.in_tok[7:5];
    assign opd    = bus.in_tok[4:0];
    assign accept = bus.in_valid & bus.in_ready;

    // Stack grows upward from bit 0; the top lives at sp-1.
    assign sp_m1   = sp - CW'(1);
    assign sp_m2   = sp - CW'(2);
    assign sp_m3   = sp - CW'(3);
    assign t1      = |(stk & (ONE << sp_m1));
    assign t2      = |(stk & (ONE << sp_m2));
    assign t3      = |(stk & (ONE << sp_m3));
    assign vec_bit = |(in_vec & (VONE << opd));

    // When sp == DEPTH the shift wraps to zero, giving an all-ones mask.
    assign low_mask = (ONE << sp) - ONE;

    always_comb begin
        res     = 1'b0;
        wpos    = sp;
        sp_new  = sp;
        tok_err = 1'b0;
        case (op)
            OP_CONST: begin
                res     = opd[0];
                sp_new  = sp + CW'(1);
                tok_err = (sp == CW'(DEPTH));
            end
            OP_VAR: begin
                res     = vec_bit;
                sp_new  = sp + CW'(1);
                tok_err = (sp == CW'(DEPTH)) || (32'(opd) >= N_IN);
            end
            OP_NOT: begin
                res     = ~t1;
                wpos    = sp_m1;
                tok_err = (sp < CW'(1));
            end
            OP_AND, OP_OR, OP_XOR: begin
                res     = (op == OP_AND) ? (t2 & t1) :
                          (op == OP_OR)  ? (t2 | t1) : (t2 ^ t1);
                wpos    = sp_m2;
                sp_new  = sp_m1;
                tok_err = (sp < CW'(2));
            end
            OP_MUX: begin
                res     = t1 ? t2 : t3;
                wpos    = sp_m3;
                sp_new  = sp_m2;
                tok_err = (sp < CW'(3));
            end
            default: begin
                tok_err = (sp == '0);
            end
        endcase
    end

    assign stk_upd = (stk & ~(ONE << wpos)) | ({{(DEPTH-1){1'b0}}, res} << wpos);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_ACC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = (state != S_EMIT);
        bus.out_valid = (state == S_EMIT);
        case (state)
            S_ACC: begin
                if (accept) begin
                    if (op == OP_END) begin
                        state_nx = S_EMIT;
                    end else if (tok_err) begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && op == OP_END) begin
                    state_nx = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    state_nx = S_ACC;
                end
            end
            default: state_nx = S_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk       <= '0;
            sp        <= '0;
            y_r       <= '0;
            y_count_r <= '0;
            err_r     <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (accept) begin
                        if (op == OP_END) begin
                            y_r       <= tok_err ? '0 : (stk & low_mask);
                            y_count_r <= tok_err ? '0 : sp;
                            err_r     <= tok_err;
                        end else if (!tok_err) begin
                            stk <= stk_upd;
                            sp  <= sp_new;
                        end
                    end
                end
                S_DRAIN: begin
                    if (accept && op == OP_END) begin
                        y_r       <= '0;
                        y_count_r <= '0;
                        err_r     <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        sp <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.y       = y_r;
    assign bus.y_count = y_count_r;
    assign bus.err     = err_r;
endmodule
